// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM encoding,
// line geometry and the index/tag width derivations.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MISS_REQ,
        MISS_WAIT,
        REFILL
    } state_e;

    localparam int LINE_BYTES = 16;
    localparam int OFFSET_W   = 2;
    localparam int WORD_W     = 32;
    localparam int CNT_W      = 32;

    function automatic int index_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int addr_w, input int lines);
        return addr_w - $clog2(LINE_BYTES) - index_w(lines);
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational read by index, synchronous write,
// and a one-cycle clear of every valid bit.
module icache_array #(
    parameter int INDEX_W   = 6,
    parameter int TAG_W     = 22,
    parameter int LINE_BITS = 128
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [INDEX_W-1:0]   rd_index,
    output logic                 rd_valid,
    output logic [TAG_W-1:0]     rd_tag,
    output logic [LINE_BITS-1:0] rd_data,
    input  logic                 wr_en,
    input  logic [INDEX_W-1:0]   wr_index,
    input  logic [TAG_W-1:0]     wr_tag,
    input  logic [LINE_BITS-1:0] wr_data
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0]     valid_q, valid_d;
    logic [TAG_W-1:0]     tag_mem  [LINES];
    logic [LINE_BITS-1:0] data_mem [LINES];

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        valid_d = valid_q;
        if (clr) begin
            valid_d = '0;
        end else if (wr_en) begin
            valid_d[wr_index] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        valid_q <= valid_d;
    end

    // NOTE: tag and data storage is deliberately not reset; the valid bits alone make stale contents harmless.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/icache_direct.sv
// Blocking direct-mapped read-only instruction cache: 1-cycle hits, single-line
// refill on a miss, and hit/miss counters.
module icache_direct
    import icache_pkg::*;
#(
    parameter int LINES     = 64,
    parameter int ADDR_W    = 32,
    parameter int LINE_BITS = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_W-1:0]    icache_addr,
    input  logic                 icache_re,
    output logic [WORD_W-1:0]    icache_dout,
    output logic                 stall,
    input  logic                 flush,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [ADDR_W-5:0]    mem_req_addr,
    input  logic                 mem_resp_valid,
    input  logic [LINE_BITS-1:0] mem_resp_data,
    output logic [CNT_W-1:0]     hit_count,
    output logic [CNT_W-1:0]     miss_count
);

    localparam int INDEX_W = index_w(LINES);
    localparam int TAG_W   = tag_w(ADDR_W, LINES);
    localparam int WORDS   = LINE_BITS / WORD_W;
    localparam int IDX_LO  = OFFSET_W + 2;

    state_e                state_q, state_d;
    logic                  pend_q, pend_d;
    logic [ADDR_W-1:2]     req_addr_q, req_addr_d;
    logic [WORD_W-1:0]     dout_q, dout_d;
    logic [CNT_W-1:0]      hit_count_q, hit_count_d;
    logic [CNT_W-1:0]      miss_count_q, miss_count_d;
    logic                  refill_q, refill_d;

    logic [OFFSET_W-1:0]   req_offset;
    logic [INDEX_W-1:0]    req_index;
    logic [TAG_W-1:0]      req_tag;
    logic                  arr_valid;
    logic [TAG_W-1:0]      arr_tag;
    logic [WORDS-1:0][WORD_W-1:0] arr_line;
    logic                  arr_wr_en;
    logic                  flush_clr;
    logic                  hit;
    logic                  unused_addr_lsb;

    assign unused_addr_lsb = ^icache_addr[1:0];

    assign req_offset = req_addr_q[IDX_LO-1:2];
    assign req_index  = req_addr_q[IDX_LO+INDEX_W-1:IDX_LO];
    assign req_tag    = req_addr_q[ADDR_W-1:IDX_LO+INDEX_W];

    icache_array #(
        .INDEX_W   (INDEX_W),
        .TAG_W     (TAG_W),
        .LINE_BITS (LINE_BITS)
    ) u_array (
        .clk      (clk),
        .clr      (reset | flush_clr),
        .rd_index (req_index),
        .rd_valid (arr_valid),
        .rd_tag   (arr_tag),
        .rd_data  (arr_line),
        .wr_en    (arr_wr_en),
        .wr_index (req_index),
        .wr_tag   (req_tag),
        .wr_data  (mem_resp_data)
    );

    assign hit = arr_valid && (arr_tag == req_tag);

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        req_addr_d   = req_addr_q;
        dout_d       = dout_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        refill_d     = 1'b0;
        stall        = 1'b0;
        mem_req_valid = 1'b0;
        arr_wr_en    = 1'b0;
        flush_clr    = 1'b0;
        icache_dout  = dout_q;

        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    if (hit) begin
                        icache_dout = arr_line[req_offset];
                        dout_d      = arr_line[req_offset];
                        // The first hit after a refill is the same request that already counted as a miss.
                        if (!refill_q) begin
                            hit_count_d = hit_count_q + CNT_W'(1);
                        end
                    end else begin
                        stall        = 1'b1;
                        miss_count_d = miss_count_q + CNT_W'(1);
                        state_d      = MISS_REQ;
                    end
                end
                if (!stall) begin
                    flush_clr = flush;
                    if (icache_re) begin
                        req_addr_d = icache_addr[ADDR_W-1:2];
                        pend_d     = 1'b1;
                    end else begin
                        pend_d = 1'b0;
                    end
                end
            end
            MISS_REQ: begin
                stall         = 1'b1;
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                stall = 1'b1;
                if (mem_resp_valid) begin
                    arr_wr_en = 1'b1;
                    state_d   = REFILL;
                end
            end
            REFILL: begin
                stall    = 1'b1;
                refill_d = 1'b1;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pend_q       <= 1'b0;
            req_addr_q   <= '0;
            dout_q       <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            refill_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            req_addr_q   <= req_addr_d;
            dout_q       <= dout_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            refill_q     <= refill_d;
        end
    end

    assign mem_req_addr = req_addr_q[ADDR_W-1:IDX_LO];
    assign hit_count    = hit_count_q;
    assign miss_count   = miss_count_q;

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Blocking, direct-mapped, read-only instruction cache between the CPU fetch port (icache_addr / icache_re / icache_dout / stall) and the main-memory request/response port.
- Serves fetch hits with 1-cycle latency.
- On a miss, raises stall and refills one 128-bit line from memory, then returns the requested word.
- Also holds hit/miss performance counters for CSR readout.

Parameters:
- LINES, 64, number of cache lines (power of 2, ≥2).
- ADDR_W, 32, byte-address width.
- LINE_BITS, 128, line size (4 words); fixed, matches the memory data bus.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- icache_addr  input  32  fetch byte address; bits [1:0] ignored
- icache_re  input  1  fetch request
- icache_dout  output  32  fetched instruction
- stall  output  1  cache busy; CPU must hold icache_addr/icache_re while high
- flush  input  1  invalidate all lines
- mem_req_valid  output  1  refill request valid
- mem_req_ready  input  1  memory accepts request
- mem_req_addr  output  28  line address (byte address [31:4])
- mem_resp_valid  input  1  refill data valid (single beat)
- mem_resp_data  input  128  refill line; word 0 in [31:0]
- hit_count  output  32  accepted requests that hit
- miss_count  output  32  accepted requests that missed

Behaviour:
Address fields:
- offset = addr[3:2]; index = addr[4+log2(LINES)-1:4]; tag = remaining upper bits.

Reset (synchronous, active-high):
- All valid bits cleared.
- State = IDLE; pend = 0.
- stall = 0, mem_req_valid = 0, icache_dout = 0, mem_req_addr = 0, hit_count = 0, miss_count = 0.
- Tag/data arrays are not reset.

Accept rule:
- A request is accepted on a cycle where icache_re = 1 and stall = 0.
- The address is registered into req_addr and pend is set. pend clears when an accepted cycle has icache_re = 0.

States:
- IDLE:
  - If pend: compare the tag at req_addr.index with req_addr.tag, with valid.
  - Hit → icache_dout = line word[offset] in the same cycle (one cycle after accept), stall = 0, hit_count += 1.
  - Miss → stall = 1 combinationally, miss_count += 1 (once per miss), go to MISS_REQ.
- MISS_REQ: mem_req_valid = 1, mem_req_addr = req_addr[31:4], stall = 1. On mem_req_ready, go to MISS_WAIT; mem_req_valid drops the next cycle.
- MISS_WAIT: stall = 1. Hold until mem_resp_valid; a response arriving in the same cycle as the ready handshake is not possible. On the response, write the data line, tag and valid bit, and go to REFILL.
- REFILL: stall = 1 for this one cycle, then return to IDLE. The pending request then hits and is not counted again as a hit. Total miss penalty = 3 + memory latency cycles.

Other rules:
- icache_dout holds its last value while stall = 1 and while there is no pending request.
- Counters wrap modulo 2^32.
- flush:
  - Acts only in IDLE with stall = 0: all valid bits clear at the next edge.
  - flush together with a pending compare: the compare uses the pre-flush valid bits. A request accepted in the same cycle as the flush sees flushed state (miss).
  - flush in any other state is ignored; it is not latched.
- Reset mid-refill: the FSM returns to IDLE immediately. Memory is reset on the same reset, so no stale response is expected; mem_resp_valid in IDLE is ignored.
- A request to the same index as a line being refilled is not possible, because the CPU is stalled.

Decomposition:
- icache_pkg holds:
  - state encoding (IDLE, MISS_REQ, MISS_WAIT, REFILL);
  - LINE_BYTES = 16, OFFSET_W = 2, and the INDEX_W/TAG_W derivation functions;
  - the counter width.
- Sub-module icache_array holds LINES×(valid, tag, 128-bit data):
  - combinational read by index;
  - synchronous write;
  - single-cycle synchronous clear-all of valid, used by both reset and flush.
- FSM and counters live in icache_direct.

Test Plan:
- Cold miss:
  - Stimulus: after reset, icache_re = 1, addr = 0x0000_1008; memory ready after 2 cycles, response 5 cycles later with data words {0x11,0x22,0x33,0x44}.
  - Required: stall high from cycle 1; mem_req_addr = 0x000_0100; icache_dout = 0x33 once stall falls; miss_count = 1, hit_count = 0.
- Hit streak:
  - Stimulus: after the above, fetch 0x1000, 0x1004, 0x100C on consecutive cycles.
  - Required: no stall; icache_dout = 0x11, 0x22, 0x44, each one cycle after its request; hit_count = 3.
- Conflict eviction (LINES = 64):
  - Stimulus: fetch 0x1008, then 0x2008 (same index), then 0x1008.
  - Required: three misses; mem_req_addr sequence 0x100, 0x200, 0x100; miss_count = 3.
- Flush:
  - Stimulus: after 0x1000 is cached, assert flush for one IDLE cycle, then fetch 0x1000.
  - Required: a miss occurs and memory is re-requested.
- Reset mid-refill:
  - Stimulus: assert reset while in MISS_WAIT.
  - Required: next cycle stall = 0, mem_req_valid = 0, counters = 0; a refetch of the same address misses.
- Backpressure:
  - Stimulus: hold mem_req_ready = 0 for 10 cycles.
  - Required: mem_req_valid and mem_req_addr remain stable throughout and stall stays high.
